// File: rtl/matrix_vector_writer_if.sv
// Request and element-write bus between a vector producer, matrix_vector_writer and a matrix write port.
// Ports: vec_in/vec_index/vec_is_col/vec_valid come from the requester, and vec_ready goes back to it.
//        write_row_addr/write_col_addr/write_data/write_ready drive the matrix. busy/done/err report status.
interface matrix_vector_writer_if #(
    parameter int unsigned NUM_ROWS    = 3,
    parameter int unsigned NUM_COLS    = 3,
    parameter int unsigned SCALAR_BITS = 32
);
    localparam int unsigned ROW_AW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned COL_AW   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned MAX_LEN  = (NUM_ROWS > NUM_COLS) ? NUM_ROWS : NUM_COLS;
    localparam int unsigned VEC_BITS = MAX_LEN * SCALAR_BITS;
    localparam int unsigned IDX_W    = (ROW_AW > COL_AW) ? ROW_AW : COL_AW;

    logic [VEC_BITS-1:0]    vec_in;
    logic [IDX_W-1:0]       vec_index;
    logic                   vec_is_col;
    logic                   vec_valid;
    logic                   vec_ready;
    logic [ROW_AW-1:0]      write_row_addr;
    logic [COL_AW-1:0]      write_col_addr;
    logic [SCALAR_BITS-1:0] write_data;
    logic                   write_ready;
    logic                   busy;
    logic                   done;
    logic                   err;

    // Requester side
    modport master (
        output vec_in, vec_index, vec_is_col, vec_valid,
        input  vec_ready, write_row_addr, write_col_addr, write_data, write_ready,
        input  busy, done, err
    );

    // Writer side
    modport slave (
        input  vec_in, vec_index, vec_is_col, vec_valid,
        output vec_ready, write_row_addr, write_col_addr, write_data, write_ready,
        output busy, done, err
    );
endinterface

// File: rtl/matrix_vector_writer.sv
// Serializes an accepted packed vector into one matrix element write per cycle, targeting a full row or a full column.
// Latency: the first write strobe comes on the cycle after the accept. A transfer is LEN back-to-back strobes, then one idle cycle.
// Backpressure: vec_ready drops for the whole transfer. The matrix side cannot stall, so every strobe is a committed write.
// Ports: clk, rst (synchronous, active-high), bus (slave modport of matrix_vector_writer_if).
module matrix_vector_writer #(
    parameter int unsigned NUM_ROWS    = 3,
    parameter int unsigned NUM_COLS    = 3,
    parameter int unsigned SCALAR_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_vector_writer_if.slave bus
);
    localparam int unsigned ROW_AW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned COL_AW   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned MAX_LEN  = (NUM_ROWS > NUM_COLS) ? NUM_ROWS : NUM_COLS;
    localparam int unsigned VEC_BITS = MAX_LEN * SCALAR_BITS;
    localparam int unsigned IDX_W    = (ROW_AW > COL_AW) ? ROW_AW : COL_AW;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       k_q, k_d;          // index of the element currently on the write port
    logic [VEC_BITS-1:0]    vec_q, vec_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   is_col_q, is_col_d;
    logic                   vec_ready_q, vec_ready_d;
    logic                   write_ready_q, write_ready_d;
    logic [ROW_AW-1:0]      row_addr_q, row_addr_d;
    logic [COL_AW-1:0]      col_addr_q, col_addr_d;
    logic [SCALAR_BITS-1:0] data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [SCALAR_BITS-1:0] elem_q [MAX_LEN];
    logic [IDX_W-1:0]       k_next;
    int unsigned            len_cur;
    int unsigned            len_in;
    logic                   in_range;

    always_comb begin
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            elem_q[i] = vec_q[i*SCALAR_BITS +: SCALAR_BITS];
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        vec_d         = vec_q;
        idx_d         = idx_q;
        is_col_d      = is_col_q;
        vec_ready_d   = vec_ready_q;
        write_ready_d = 1'b0;
        row_addr_d    = row_addr_q;
        col_addr_d    = col_addr_q;
        data_d        = data_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;

        k_next   = k_q + IDX_W'(1);
        len_cur  = is_col_q ? NUM_ROWS : NUM_COLS;
        len_in   = bus.vec_is_col ? NUM_ROWS : NUM_COLS;
        // A column index addresses NUM_COLS columns. A row index addresses NUM_ROWS rows.
        in_range = bus.vec_is_col ? (32'(bus.vec_index) < NUM_COLS)
                                  : (32'(bus.vec_index) < NUM_ROWS);

        case (state_q)
            IDLE: begin
                vec_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (bus.vec_valid && vec_ready_q) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else begin
                        // Present element 0 straight from the input, so the first strobe lands right after the accept.
                        state_d       = WRITE;
                        k_d           = '0;
                        vec_d         = bus.vec_in;
                        idx_d         = bus.vec_index;
                        is_col_d      = bus.vec_is_col;
                        vec_ready_d   = 1'b0;
                        busy_d        = 1'b1;
                        write_ready_d = 1'b1;
                        data_d        = bus.vec_in[SCALAR_BITS-1:0];
                        row_addr_d    = bus.vec_is_col ? '0 : ROW_AW'(bus.vec_index);
                        col_addr_d    = bus.vec_is_col ? COL_AW'(bus.vec_index) : '0;
                        done_d        = (len_in == 32'd1);
                    end
                end
            end
            WRITE: begin
                if (32'(k_q) == len_cur - 32'd1) begin
                    state_d     = IDLE;
                    vec_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    k_d           = k_next;
                    write_ready_d = 1'b1;
                    data_d        = elem_q[k_next];
                    row_addr_d    = is_col_q ? ROW_AW'(k_next) : ROW_AW'(idx_q);
                    col_addr_d    = is_col_q ? COL_AW'(idx_q) : COL_AW'(k_next);
                    done_d        = (32'(k_next) == len_cur - 32'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            vec_q         <= '0;
            idx_q         <= '0;
            is_col_q      <= 1'b0;
            vec_ready_q   <= 1'b0;
            write_ready_q <= 1'b0;
            row_addr_q    <= '0;
            col_addr_q    <= '0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            vec_q         <= vec_d;
            idx_q         <= idx_d;
            is_col_q      <= is_col_d;
            vec_ready_q   <= vec_ready_d;
            write_ready_q <= write_ready_d;
            row_addr_q    <= row_addr_d;
            col_addr_q    <= col_addr_d;
            data_q        <= data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign bus.vec_ready      = vec_ready_q;
    assign bus.write_ready    = write_ready_q;
    assign bus.write_row_addr = row_addr_q;
    assign bus.write_col_addr = col_addr_q;
    assign bus.write_data     = data_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
endmodule

// File: tb/tb_matrix_vector_writer.sv
// Testbench for matrix_vector_writer on a 3x3 matrix with 32-bit elements. A small matrix stub absorbs the write strobes.
// Latency: the bench expects the first strobe one cycle after accept and LEN gap-free strobes per transfer.
// Backpressure: it holds vec_valid and checks that vec_ready stays low for the whole transfer.
module tb_matrix_vector_writer;
    localparam int R  = 3;
    localparam int C  = 3;
    localparam int SB = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [SB-1:0] mat     [R][C];  // matrix stub fed by the strobes
    logic [SB-1:0] exp_mat [R][C];  // reference contents

    matrix_vector_writer_if #(.NUM_ROWS(R), .NUM_COLS(C), .SCALAR_BITS(SB)) vif ();

    matrix_vector_writer #(.NUM_ROWS(R), .NUM_COLS(C), .SCALAR_BITS(SB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vif.write_ready && int'(vif.write_row_addr) < R && int'(vif.write_col_addr) < C)
            mat[vif.write_row_addr][vif.write_col_addr] <= vif.write_data;
    end

    // Status flags in the order {write_ready, busy, vec_ready, done, err}
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({vif.write_ready, vif.busy, vif.vec_ready, vif.done, vif.err} !== 5'b00000) begin
            $display("FAIL reset_during flags got %b exp 00000",
                     {vif.write_ready, vif.busy, vif.vec_ready, vif.done, vif.err});
        end else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({vif.write_ready, vif.busy, vif.vec_ready, vif.done, vif.err} !== 5'b00100) begin
            $display("FAIL reset_after flags got %b exp 00100",
                     {vif.write_ready, vif.busy, vif.vec_ready, vif.done, vif.err});
        end else n_pass++;
        n_checks++;
        if ({vif.write_row_addr, vif.write_col_addr, vif.write_data} !== 36'd0) begin
            $display("FAIL reset_bus got %h/%h/%h exp 0/0/0",
                     vif.write_row_addr, vif.write_col_addr, vif.write_data);
        end else n_pass++;
    endtask

    // One full transfer. The request inputs are scrambled every write cycle, so only the latched copy can give the right data.
    task automatic test_one_transfer(input logic [3*SB-1:0] v, input int idx, input bit col, input string name);
        int            len;
        logic [1:0]    er, ec;
        logic [SB-1:0] ed;
        len = col ? R : C;
        n_checks++;
        if (vif.vec_ready !== 1'b1) begin
            $display("FAIL %s ready_before got %b exp 1", name, vif.vec_ready);
        end else n_pass++;
        vif.vec_in     = v;
        vif.vec_index  = 2'(idx);
        vif.vec_is_col = col;
        vif.vec_valid  = 1'b1;
        @(negedge clk);
        vif.vec_valid = 1'b0;
        for (int k = 0; k < len; k++) begin
            er = col ? 2'(k) : 2'(idx);
            ec = col ? 2'(idx) : 2'(k);
            ed = v[k*SB +: SB];
            n_checks++;
            if ({vif.write_ready, vif.busy, vif.vec_ready, vif.done, vif.err} !== {3'b110, (k == len-1), 1'b0}) begin
                $display("FAIL %s flags k=%0d got %b exp %b", name, k,
                         {vif.write_ready, vif.busy, vif.vec_ready, vif.done, vif.err},
                         {3'b110, (k == len-1), 1'b0});
            end else n_pass++;
            n_checks++;
            if ({vif.write_row_addr, vif.write_col_addr, vif.write_data} !== {er, ec, ed}) begin
                $display("FAIL %s strobe k=%0d got (%0d,%0d,%h) exp (%0d,%0d,%h)", name, k,
                         vif.write_row_addr, vif.write_col_addr, vif.write_data, er, ec, ed);
            end else n_pass++;
            exp_mat[er][ec] = ed;
            vif.vec_in     = {$urandom, $urandom, $urandom};
            vif.vec_index  = 2'($urandom);
            vif.vec_is_col = 1'($urandom);
            @(negedge clk);
        end
        n_checks++;
        if ({vif.write_ready, vif.busy, vif.vec_ready, vif.done, vif.err} !== 5'b00100) begin
            $display("FAIL %s idle_after got %b exp 00100", name,
                     {vif.write_ready, vif.busy, vif.vec_ready, vif.done, vif.err});
        end else n_pass++;
    endtask

    task automatic test_matrix(input string name);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                n_checks++;
                if (mat[r][c] !== exp_mat[r][c]) begin
                    $display("FAIL %s mat[%0d][%0d] got %h exp %h", name, r, c, mat[r][c], exp_mat[r][c]);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_out_of_range(input bit col);
        vif.vec_in     = {$urandom, $urandom, $urandom};
        vif.vec_index  = 2'd3;
        vif.vec_is_col = col;
        vif.vec_valid  = 1'b1;
        @(negedge clk);
        vif.vec_valid = 1'b0;
        n_checks++;
        if ({vif.write_ready, vif.busy, vif.vec_ready, vif.done, vif.err} !== 5'b00101) begin
            $display("FAIL oor col=%0d err_cycle got %b exp 00101", col,
                     {vif.write_ready, vif.busy, vif.vec_ready, vif.done, vif.err});
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({vif.write_ready, vif.busy, vif.vec_ready, vif.done, vif.err} !== 5'b00100) begin
            $display("FAIL oor col=%0d after got %b exp 00100", col,
                     {vif.write_ready, vif.busy, vif.vec_ready, vif.done, vif.err});
        end else n_pass++;
    endtask

    // Row 0, then column 0, with vec_valid held high. The second request is already waiting when the first one finishes.
    task automatic test_back_to_back();
        logic [3*SB-1:0] va, vb, v;
        logic [1:0]      er, ec;
        logic [SB-1:0]   ed;
        bit              col;
        va = {$urandom, $urandom, $urandom};
        vb = {$urandom, $urandom, $urandom};
        vif.vec_in = va; vif.vec_index = 2'd0; vif.vec_is_col = 1'b0; vif.vec_valid = 1'b1;
        @(negedge clk);
        vif.vec_in = vb; vif.vec_index = 2'd0; vif.vec_is_col = 1'b1;
        for (int t = 0; t < 2; t++) begin
            v   = (t == 0) ? va : vb;
            col = (t == 1);
            for (int k = 0; k < 3; k++) begin
                er = col ? 2'(k) : 2'd0;
                ec = col ? 2'd0 : 2'(k);
                ed = v[k*SB +: SB];
                n_checks++;
                if ({vif.write_ready, vif.done, vif.write_row_addr, vif.write_col_addr, vif.write_data} !==
                    {1'b1, (k == 2), er, ec, ed}) begin
                    $display("FAIL b2b t=%0d k=%0d got wr=%b dn=%b (%0d,%0d,%h) exp (%0d,%0d,%h)", t, k,
                             vif.write_ready, vif.done, vif.write_row_addr, vif.write_col_addr,
                             vif.write_data, er, ec, ed);
                end else n_pass++;
                exp_mat[er][ec] = ed;
                @(negedge clk);
            end
            n_checks++;
            if ({vif.write_ready, vif.busy, vif.vec_ready} !== 3'b001) begin
                $display("FAIL b2b gap t=%0d got %b exp 001", t, {vif.write_ready, vif.busy, vif.vec_ready});
            end else n_pass++;
            if (t == 0) begin
                @(negedge clk);
                vif.vec_valid = 1'b0;
            end
        end
        n_checks++;
        if (mat[0][0] !== vb[SB-1:0]) begin
            $display("FAIL b2b corner got %h exp %h", mat[0][0], vb[SB-1:0]);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [3*SB-1:0] v;
        int              idx;
        v   = {$urandom, $urandom, $urandom};
        idx = int'($urandom_range(0, 2));
        vif.vec_in = v; vif.vec_index = 2'(idx); vif.vec_is_col = 1'b0; vif.vec_valid = 1'b1;
        @(negedge clk);
        vif.vec_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({vif.write_ready, vif.write_data} !== {1'b1, v[k*SB +: SB]}) begin
                $display("FAIL rstmid k=%0d got %b/%h exp 1/%h", k, vif.write_ready, vif.write_data, v[k*SB +: SB]);
            end else n_pass++;
            exp_mat[idx][k] = v[k*SB +: SB];
            if (k == 0) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({vif.write_ready, vif.busy, vif.done, vif.vec_ready} !== 4'b0000) begin
            $display("FAIL rstmid flags got %b exp 0000", {vif.write_ready, vif.busy, vif.done, vif.vec_ready});
        end else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({vif.write_ready, vif.busy, vif.vec_ready} !== 3'b001) begin
            $display("FAIL rstmid recover got %b exp 001", {vif.write_ready, vif.busy, vif.vec_ready});
        end else n_pass++;
        test_matrix("rstmid_mat");
        test_one_transfer({$urandom, $urandom, $urandom}, int'($urandom_range(0, 2)), 1'($urandom), "post_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            test_one_transfer({$urandom, $urandom, $urandom}, int'($urandom_range(0, 2)), 1'($urandom), "rand");
        end
    endtask

    initial begin
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                mat[r][c]     = '0;
                exp_mat[r][c] = '0;
            end
        end
        vif.vec_in     = '0;
        vif.vec_index  = '0;
        vif.vec_is_col = 1'b0;
        vif.vec_valid  = 1'b0;

        test_reset();
        test_one_transfer({32'h3, 32'h2, 32'h1}, 1, 1'b0, "row_write");
        test_matrix("row_mat");
        test_one_transfer({32'hC, 32'hB, 32'hA}, 2, 1'b1, "col_write");
        test_matrix("col_mat");
        test_back_to_back();
        test_out_of_range(1'b0);
        test_out_of_range(1'b1);
        test_matrix("oor_mat");
        test_reset_mid();
        test_random();
        test_matrix("final_mat");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/matrix_vector_writer.md
Name: matrix_vector_writer

Overview:
- Write-side companion of the matrix row/column read ports.
- Accepts a whole packed vector through a valid/ready handshake and serializes it into one element write per cycle on the matrix element-write port (write_row_addr / write_col_addr / write_data / write_ready).
- The target is a full row or a full column, selected per transfer.
- Used to store vector_reg contents or computed vectors back into a matrix instance.

Parameters:
NUM_ROWS, 3, matrix rows
NUM_COLS, 3, matrix columns
SCALAR_BITS, 32, element width
(derived) ROW_ADDR_WIDTH = $clog2(NUM_ROWS), COL_ADDR_WIDTH = $clog2(NUM_COLS), MAX_LEN = max(NUM_ROWS,NUM_COLS), VEC_BITS = MAX_LEN*SCALAR_BITS, IDX_WIDTH = max(ROW_ADDR_WIDTH,COL_ADDR_WIDTH)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
vec_in  in  VEC_BITS  packed vector; element i = vec_in[i*SCALAR_BITS +: SCALAR_BITS], element 0 at LSB
vec_index  in  IDX_WIDTH  target row (row mode) or column (column mode)
vec_is_col  in  1  0 = write row vec_index, 1 = write column vec_index
vec_valid  in  1  request valid
vec_ready  out  1  block can accept a request
write_row_addr  out  ROW_ADDR_WIDTH  to matrix element-write port
write_col_addr  out  COL_ADDR_WIDTH  to matrix element-write port
write_data  out  SCALAR_BITS  to matrix element-write port
write_ready  out  1  element write strobe, one element per cycle
busy  out  1  transfer in progress
done  out  1  one-cycle pulse on the cycle of the last element write
err  out  1  one-cycle pulse: request rejected (index out of range)

Behaviour:
- All outputs registered. Reset values: vec_ready=0 during rst, 1 on the first cycle after rst deasserts; write_ready=0; busy=0; done=0; err=0; write_row_addr=0; write_col_addr=0; write_data=0.
- FSM states: IDLE, WRITE.
- IDLE: vec_ready=1, write_ready=0.
  - Accept when vec_valid && vec_ready at a rising edge: latch vec_in, vec_index, vec_is_col; clear element counter k=0.
  - LEN = NUM_COLS in row mode, NUM_ROWS in column mode. Elements k >= LEN of vec_in are ignored.
- Range check at accept: row mode requires vec_index < NUM_ROWS; column mode requires vec_index < NUM_COLS.
  - Violation: stay in IDLE, err=1 for the next cycle, no writes issued.
  - Otherwise go to WRITE, with vec_ready=0 and busy=1 from the next cycle.
- WRITE, cycle k (k = 0..LEN-1):
  - write_ready=1 and write_data = element k.
  - Row mode: write_row_addr = index, write_col_addr = k.
  - Column mode: write_row_addr = k, write_col_addr = index.
- Latency: first write strobe appears on the cycle immediately after the accept edge. A transfer takes exactly LEN write cycles with no gaps.
- On k = LEN-1: done=1 in the same cycle. Next cycle: IDLE, write_ready=0, busy=0, vec_ready=1.
- Throughput: one vector per LEN+1 cycles.
- No backpressure from the matrix. Every write_ready cycle is a committed write.
- vec_in, vec_index and vec_is_col changes during WRITE have no effect (latched copy used).
- vec_valid held high continuously: the next request is accepted on the first IDLE cycle after done.
- Reset mid-transfer: at the rst edge, state goes to IDLE and the counter clears. write_ready, busy and done are 0 the following cycle. The transfer is abandoned; writes already issued are not undone.
- Degenerate dimension 1: LEN=1 gives a single write cycle with done asserted in it.

Test Plan:
1. Row write (3x3, 32-bit): reset, then request vec_in={32'h3,32'h2,32'h1}, index=1, row mode -> three consecutive strobes (1,0,1), (1,1,2), (1,2,3); done on the third; read row 1 back from the matrix = {3,2,1}.
2. Column write: vec_in={32'hC,32'hB,32'hA}, index=2, column mode -> strobes (0,2,A), (1,2,B), (2,2,C); read column 2 back = {C,B,A}; other entries unchanged.
3. Back-to-back: vec_valid held high with two queued requests (row 0, then column 0) -> 3 writes, 1 idle cycle with vec_ready=1, then 3 writes; element (0,0) ends with the column value.
4. Out of range: index=3, row mode -> err pulse for 1 cycle, write_ready stays 0, vec_ready stays 1.
5. Input change during WRITE: modify vec_in after accept -> written data equals the originally latched values.
6. Reset after the 2nd write strobe of a row transfer -> write_ready=0 and busy=0 the next cycle; only elements 0-1 of the row were updated; a new request is accepted normally afterwards.
